// File: rtl/mc_cu_if.sv
// Control-unit bus: instruction fields and status in, datapath control strobes out.
// The master side is the datapath and the slave side is the control unit.
interface mc_cu_if;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned STATE_W = 3;

  logic [FIELD_W-1:0] op;
  logic [FIELD_W-1:0] func;
  logic               z;
  logic               mem_ready;

  logic               wpc;
  logic               wir;
  logic               wmem;
  logic               wreg;
  logic               iord;
  logic               regrt;
  logic               m2reg;
  logic               jal;
  logic               sext;
  logic               shift;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [3:0]         aluc;
  logic [1:0]         pcsource;
  logic [STATE_W-1:0] state;

  modport master (
    output op, func, z, mem_ready,
    input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
           alusrca, alusrcb, aluc, pcsource, state
  );

  modport slave (
    input  op, func, z, mem_ready,
    output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
           alusrca, alusrcb, aluc, pcsource, state
  );
endinterface

// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with combinational
// control strobes decoded from the current state and the instruction register.
module mc_cu #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit HAMMING_EN  = 1'b1
) (
  input logic    clock,
  input logic    reset,
  mc_cu_if.slave bus
);
  localparam int unsigned FW = 6;

  localparam logic [FW-1:0] OP_R    = 6'b000000;
  localparam logic [FW-1:0] OP_ADDI = 6'b001000;
  localparam logic [FW-1:0] OP_ANDI = 6'b001100;
  localparam logic [FW-1:0] OP_ORI  = 6'b001101;
  localparam logic [FW-1:0] OP_XORI = 6'b001110;
  localparam logic [FW-1:0] OP_LUI  = 6'b001111;
  localparam logic [FW-1:0] OP_LW   = 6'b100011;
  localparam logic [FW-1:0] OP_SW   = 6'b101011;
  localparam logic [FW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [FW-1:0] OP_BNE  = 6'b000101;
  localparam logic [FW-1:0] OP_J    = 6'b000010;
  localparam logic [FW-1:0] OP_JAL  = 6'b000011;

  localparam logic [FW-1:0] F_ADD = 6'b100000;
  localparam logic [FW-1:0] F_SUB = 6'b100010;
  localparam logic [FW-1:0] F_AND = 6'b100100;
  localparam logic [FW-1:0] F_OR  = 6'b100101;
  localparam logic [FW-1:0] F_XOR = 6'b100110;
  localparam logic [FW-1:0] F_SLL = 6'b000000;
  localparam logic [FW-1:0] F_SRL = 6'b000010;
  localparam logic [FW-1:0] F_SRA = 6'b000011;
  localparam logic [FW-1:0] F_JR  = 6'b001000;
  localparam logic [FW-1:0] F_HAM = 6'b110001;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic rtype, rdy;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_ham;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic alu_r, alu_i, shift_op, imm_op, sext_op, rt_op, legal;
  logic [3:0] aluc_dec;

  // Instruction decode
  assign rtype  = (bus.op == OP_R);
  assign i_add  = rtype && (bus.func == F_ADD);
  assign i_sub  = rtype && (bus.func == F_SUB);
  assign i_and  = rtype && (bus.func == F_AND);
  assign i_or   = rtype && (bus.func == F_OR);
  assign i_xor  = rtype && (bus.func == F_XOR);
  assign i_sll  = rtype && (bus.func == F_SLL);
  assign i_srl  = rtype && (bus.func == F_SRL);
  assign i_sra  = rtype && (bus.func == F_SRA);
  assign i_jr   = rtype && (bus.func == F_JR);
  assign i_ham  = HAMMING_EN && rtype && (bus.func == F_HAM);
  assign i_addi = (bus.op == OP_ADDI);
  assign i_andi = (bus.op == OP_ANDI);
  assign i_ori  = (bus.op == OP_ORI);
  assign i_xori = (bus.op == OP_XORI);
  assign i_lui  = (bus.op == OP_LUI);
  assign i_lw   = (bus.op == OP_LW);
  assign i_sw   = (bus.op == OP_SW);
  assign i_beq  = (bus.op == OP_BEQ);
  assign i_bne  = (bus.op == OP_BNE);
  assign i_j    = (bus.op == OP_J);
  assign i_jal  = (bus.op == OP_JAL);

  assign alu_r    = i_add || i_sub || i_and || i_or || i_xor || i_sll || i_srl || i_sra || i_ham;
  assign alu_i    = i_addi || i_andi || i_ori || i_xori || i_lui;
  assign shift_op = i_sll || i_srl || i_sra;
  assign imm_op   = alu_i || i_lw || i_sw;
  assign sext_op  = i_addi || i_lw || i_sw || i_beq || i_bne;
  assign rt_op    = i_addi || i_andi || i_ori || i_xori || i_lw || i_lui;
  assign legal    = alu_r || alu_i || i_lw || i_sw || i_beq || i_bne || i_j || i_jal || i_jr;

  // With waits disabled every memory access completes in one cycle
  assign rdy = bus.mem_ready || !MEM_WAIT_EN;

  // ALU operation for the EXE phase
  always_comb begin
    aluc_dec = 4'b0000;
    if (i_sub)                          aluc_dec = 4'b0100;
    else if (i_and || i_andi)           aluc_dec = 4'b0001;
    else if (i_or || i_ori)             aluc_dec = 4'b0101;
    else if (i_xor || i_xori || i_beq || i_bne) aluc_dec = 4'b0010;
    else if (i_lui)                     aluc_dec = 4'b0110;
    else if (i_sll)                     aluc_dec = 4'b0011;
    else if (i_srl)                     aluc_dec = 4'b0111;
    else if (i_sra)                     aluc_dec = 4'b1111;
    else if (i_ham)                     aluc_dec = 4'b1001;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign bus.state = state_q;

  // Next state and control strobes
  always_comb begin
    state_d      = S_IF;
    bus.wpc      = 1'b0;
    bus.wir      = 1'b0;
    bus.wmem     = 1'b0;
    bus.wreg     = 1'b0;
    bus.iord     = 1'b0;
    bus.regrt    = 1'b0;
    bus.m2reg    = 1'b0;
    bus.jal      = 1'b0;
    bus.sext     = 1'b0;
    bus.shift    = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluc     = 4'b0000;
    bus.pcsource = 2'b00;
    case (state_q)
      S_IF: begin
        bus.wpc     = rdy;
        bus.wir     = rdy;
        bus.alusrcb = 2'b01;
        state_d     = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        bus.alusrcb = 2'b11;
        bus.sext    = 1'b1;
        if (i_j || i_jal || i_jr) begin
          bus.wpc      = 1'b1;
          bus.pcsource = i_jr ? 2'b10 : 2'b11;
          bus.wreg     = i_jal;
          bus.jal      = i_jal;
        end else if (legal) begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        bus.alusrca = 1'b1;
        bus.shift   = shift_op;
        bus.alusrcb = imm_op ? 2'b10 : 2'b00;
        bus.sext    = sext_op;
        bus.aluc    = aluc_dec;
        if (i_beq || i_bne) begin
          bus.pcsource = 2'b01;
          bus.wpc      = (i_beq && bus.z) || (i_bne && !bus.z);
        end else if (i_lw || i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        bus.iord = 1'b1;
        bus.wmem = i_sw;
        if (!rdy)      state_d = S_MEM;
        else if (i_lw) state_d = S_WB;
      end
      S_WB: begin
        bus.wreg  = 1'b1;
        bus.m2reg = i_lw;
        bus.regrt = rt_op;
      end
      default: state_d = S_IF;
    endcase
  end
endmodule

// File: tb/tb_mc_cu.sv
// Randomized bench for mc_cu: an instruction-level model expands each instruction
// into its phase list and predicts every control strobe cycle by cycle.
module tb_mc_cu;
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_HAM = 8, K_ILL = 9;
  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;
  localparam int NTBL = 21;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] kind;
    logic [3:0] aluc;
    logic imm, sx, rt, sh;
  } ins_t;

  typedef struct packed {
    logic [2:0] state;
    logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
  } out_t;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  ins_t tbl [NTBL];

  mc_cu_if bus_a ();
  mc_cu_if bus_b ();

  mc_cu #(.MEM_WAIT_EN(1'b1), .HAMMING_EN(1'b1)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mc_cu #(.MEM_WAIT_EN(1'b0), .HAMMING_EN(1'b0)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic ins_t mk(logic [5:0] op, logic [5:0] func, int kind, logic [3:0] aluc,
                              bit imm, bit sx, bit rt, bit sh);
    ins_t r;
    r.op = op; r.func = func; r.kind = 4'(kind); r.aluc = aluc;
    r.imm = imm; r.sx = sx; r.rt = rt; r.sh = sh;
    return r;
  endfunction

  // Look an (op, func) pair up in the ISA table; anything unmatched is illegal
  function automatic ins_t classify(logic [5:0] op, logic [5:0] func);
    ins_t r;
    r = mk(op, func, K_ILL, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NTBL; i++)
      if (tbl[i].op == op && (op != 6'd0 || tbl[i].func == func)) begin
        r = tbl[i];
        r.func = func;
      end
    return r;
  endfunction

  function automatic int eff_kind(ins_t ins, bit ham_en);
    if (int'(ins.kind) == K_HAM) return ham_en ? K_ALU : K_ILL;
    return int'(ins.kind);
  endfunction

  function automatic out_t expect_vec(int p, ins_t ins, int k, bit zv, bit rdy, bit wait_en);
    out_t e;
    e = '0;
    e.state = 3'(p);
    case (p)
      P_IF: begin
        e.wpc = rdy || !wait_en;
        e.wir = e.wpc;
        e.alusrcb = 2'b01;
      end
      P_ID: begin
        e.alusrcb = 2'b11;
        e.sext = 1'b1;
        if (k == K_J || k == K_JAL) begin e.wpc = 1'b1; e.pcsource = 2'b11; end
        if (k == K_JAL) begin e.wreg = 1'b1; e.jal = 1'b1; end
        if (k == K_JR) begin e.wpc = 1'b1; e.pcsource = 2'b10; end
      end
      P_EXE: begin
        e.alusrca = 1'b1;
        e.shift = ins.sh;
        e.alusrcb = ins.imm ? 2'b10 : 2'b00;
        e.sext = ins.sx;
        e.aluc = ins.aluc;
        if (k == K_BEQ || k == K_BNE) begin
          e.pcsource = 2'b01;
          e.wpc = (k == K_BEQ) ? zv : !zv;
        end
      end
      P_MEM: begin
        e.iord = 1'b1;
        e.wmem = (k == K_SW);
      end
      default: begin
        e.wreg = 1'b1;
        e.m2reg = (k == K_LW);
        e.regrt = ins.rt;
      end
    endcase
    return e;
  endfunction

  function automatic out_t sample(bit alt);
    if (alt)
      return {bus_b.state, bus_b.wpc, bus_b.wir, bus_b.wmem, bus_b.wreg, bus_b.iord, bus_b.regrt,
              bus_b.m2reg, bus_b.jal, bus_b.sext, bus_b.shift, bus_b.alusrca, bus_b.alusrcb,
              bus_b.aluc, bus_b.pcsource};
    return {bus_a.state, bus_a.wpc, bus_a.wir, bus_a.wmem, bus_a.wreg, bus_a.iord, bus_a.regrt,
            bus_a.m2reg, bus_a.jal, bus_a.sext, bus_a.shift, bus_a.alusrca, bus_a.alusrcb,
            bus_a.aluc, bus_a.pcsource};
  endfunction

  task automatic drive(input bit alt, input logic [5:0] op, input logic [5:0] func,
                       input bit zv, input bit rdy);
    if (alt) begin
      bus_b.op = op; bus_b.func = func; bus_b.z = zv; bus_b.mem_ready = rdy;
    end else begin
      bus_a.op = op; bus_a.func = func; bus_a.z = zv; bus_a.mem_ready = rdy;
    end
  endtask

  // Execute one instruction: mem_waits<0 randomizes ready, zf<0 randomizes z,
  // cut_phase>=0 asserts reset during that phase and abandons the instruction
  task automatic run_instr(input bit alt, input ins_t ins, input int mem_waits,
                           input int zf, input int cut_phase);
    bit wait_en, zv, rdy, stay;
    int k, waits, p;
    int ph[$];
    string tag;
    wait_en = !alt;
    k = eff_kind(ins, !alt);
    ph = '{P_IF, P_ID};
    if (k == K_ALU) ph = '{P_IF, P_ID, P_EXE, P_WB};
    if (k == K_LW)  ph = '{P_IF, P_ID, P_EXE, P_MEM, P_WB};
    if (k == K_SW)  ph = '{P_IF, P_ID, P_EXE, P_MEM};
    if (k == K_BEQ || k == K_BNE) ph = '{P_IF, P_ID, P_EXE};
    foreach (ph[i]) begin
      p = ph[i];
      waits = 0;
      do begin
        @(negedge clock);
        reset = 1'b0;
        zv = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
        if (p == P_MEM && mem_waits >= 0) rdy = (waits >= mem_waits);
        else if (p == P_IF && mem_waits >= 0) rdy = 1'b1;
        else rdy = (waits >= 4) || ($urandom_range(0, 2) != 0);
        if (p == P_IF) drive(alt, 6'($urandom), 6'($urandom), zv, rdy);
        else drive(alt, ins.op, ins.func, zv, rdy);
        #1;
        tag = $sformatf("%s op=%h fn=%h ph=%0d", alt ? "b" : "a", ins.op, ins.func, p);
        check_eq(tag, 32'(sample(alt)), 32'(expect_vec(p, ins, k, zv, rdy, wait_en)));
        if (p == cut_phase) begin
          reset = 1'b1;
          #1 check_eq({tag, " rst"}, 32'(sample(alt)),
                      32'(expect_vec(P_IF, ins, k, zv, rdy, wait_en)));
          @(negedge clock);
          rdy = 1'($urandom_range(0, 1));
          drive(alt, ins.op, ins.func, zv, rdy);
          #1 check_eq({tag, " rst_hold"}, 32'(sample(alt)),
                      32'(expect_vec(P_IF, ins, k, zv, rdy, wait_en)));
          return;
        end
        waits++;
        stay = (p == P_IF || p == P_MEM) && wait_en && !rdy;
      end while (stay);
    end
  endtask

  function automatic ins_t rand_ins();
    ins_t r;
    if ($urandom_range(0, 3) != 0) begin
      r = tbl[$urandom_range(0, NTBL - 1)];
      if (r.op != 6'd0) r.func = 6'($urandom);
    end else begin
      r = classify(6'($urandom), 6'($urandom));
    end
    return r;
  endfunction

  initial begin
    tbl[0]  = mk(6'h00, 6'b100000, K_ALU, 4'b0000, 0, 0, 0, 0);
    tbl[1]  = mk(6'h00, 6'b100010, K_ALU, 4'b0100, 0, 0, 0, 0);
    tbl[2]  = mk(6'h00, 6'b100100, K_ALU, 4'b0001, 0, 0, 0, 0);
    tbl[3]  = mk(6'h00, 6'b100101, K_ALU, 4'b0101, 0, 0, 0, 0);
    tbl[4]  = mk(6'h00, 6'b100110, K_ALU, 4'b0010, 0, 0, 0, 0);
    tbl[5]  = mk(6'h00, 6'b000000, K_ALU, 4'b0011, 0, 0, 0, 1);
    tbl[6]  = mk(6'h00, 6'b000010, K_ALU, 4'b0111, 0, 0, 0, 1);
    tbl[7]  = mk(6'h00, 6'b000011, K_ALU, 4'b1111, 0, 0, 0, 1);
    tbl[8]  = mk(6'h00, 6'b001000, K_JR,  4'b0000, 0, 0, 0, 0);
    tbl[9]  = mk(6'h00, 6'b110001, K_HAM, 4'b1001, 0, 0, 0, 0);
    tbl[10] = mk(6'b001000, 6'h00, K_ALU, 4'b0000, 1, 1, 1, 0);
    tbl[11] = mk(6'b001100, 6'h00, K_ALU, 4'b0001, 1, 0, 1, 0);
    tbl[12] = mk(6'b001101, 6'h00, K_ALU, 4'b0101, 1, 0, 1, 0);
    tbl[13] = mk(6'b001110, 6'h00, K_ALU, 4'b0010, 1, 0, 1, 0);
    tbl[14] = mk(6'b001111, 6'h00, K_ALU, 4'b0110, 1, 0, 1, 0);
    tbl[15] = mk(6'b100011, 6'h00, K_LW,  4'b0000, 1, 1, 1, 0);
    tbl[16] = mk(6'b101011, 6'h00, K_SW,  4'b0000, 1, 1, 0, 0);
    tbl[17] = mk(6'b000100, 6'h00, K_BEQ, 4'b0010, 0, 1, 0, 0);
    tbl[18] = mk(6'b000101, 6'h00, K_BNE, 4'b0010, 0, 1, 0, 0);
    tbl[19] = mk(6'b000010, 6'h00, K_J,   4'b0000, 0, 0, 0, 0);
    tbl[20] = mk(6'b000011, 6'h00, K_JAL, 4'b0000, 0, 0, 0, 0);

    reset = 1'b1;
    drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    drive(1'b1, 6'h00, 6'h00, 1'b0, 1'b0);

    // Outputs under reset: IF values with fetch strobes following mem_ready
    @(negedge clock);
    #1 check_eq("rst_a_rdy0", 32'(sample(1'b0)), 32'(expect_vec(P_IF, tbl[0], K_ILL, 0, 0, 1)));
    bus_a.mem_ready = 1'b1;
    #1 check_eq("rst_a_rdy1", 32'(sample(1'b0)), 32'(expect_vec(P_IF, tbl[0], K_ILL, 0, 1, 1)));
    #1 check_eq("rst_b_rdy0", 32'(sample(1'b1)), 32'(expect_vec(P_IF, tbl[0], K_ILL, 0, 0, 0)));

    run_instr(1'b0, classify(6'h00, 6'b100000), 0, -1, -1);
    run_instr(1'b0, classify(6'b100011, 6'h00), 2, -1, -1);
    run_instr(1'b0, classify(6'b000100, 6'h00), 0, 1, -1);
    run_instr(1'b0, classify(6'b000100, 6'h00), 0, 0, -1);
    run_instr(1'b0, classify(6'b000101, 6'h00), 0, 1, -1);
    run_instr(1'b0, classify(6'b000101, 6'h00), 0, 0, -1);
    run_instr(1'b0, classify(6'b000011, 6'h00), 0, -1, -1);
    run_instr(1'b0, classify(6'h00, 6'b110001), 0, -1, -1);
    run_instr(1'b0, classify(6'b101011, 6'h00), 5, -1, P_MEM);
    run_instr(1'b0, classify(6'h00, 6'b100010), 0, -1, P_WB);
    run_instr(1'b0, classify(6'b111111, 6'h00), 0, -1, -1);
    for (int i = 0; i < 200; i++) run_instr(1'b0, rand_ins(), -1, -1, -1);
    run_instr(1'b0, classify(6'b000010, 6'h00), -1, -1, -1);

    reset = 1'b1;
    @(negedge clock);
    run_instr(1'b1, classify(6'h00, 6'b110001), -1, -1, -1);
    run_instr(1'b1, classify(6'b100011, 6'h00), -1, -1, -1);
    run_instr(1'b1, classify(6'b101011, 6'h00), -1, -1, -1);
    for (int i = 0; i < 100; i++) run_instr(1'b1, rand_ins(), -1, -1, -1);
    run_instr(1'b1, classify(6'b000010, 6'h00), -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: 1 = memory phases honour mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 Parameter HAMMING_EN, default 1: 1 = R-type func 110001 (hamming) is decoded; 0 = that func is illegal.
REQ-003 clock  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op  in  6  opcode field of the instruction register (IR).
REQ-006 func  in  6  function field of IR.
REQ-007 z  in  1  ALU zero flag, valid in EXE.
REQ-008 mem_ready  in  1  memory completes the current access this cycle.
REQ-009 wpc  out  1  PC write enable.
REQ-010 wir  out  1  IR write enable.
REQ-011 wmem  out  1  memory write enable.
REQ-012 wreg  out  1  register-file write enable.
REQ-013 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-014 regrt / m2reg / jal / sext / shift  out  1 each  same meanings as the single-cycle unit.
REQ-015 alusrca  out  1  ALU A select: 0 = PC, 1 = register rs (or sa when shift=1).
REQ-016 alusrcb  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
REQ-017 aluc  out  4  ALU operation code.
REQ-018 pcsource  out  2  PC select: 00 = ALU, 01 = ALUOut (branch target), 10 = rs (jr), 11 = jump address.
REQ-019 state  out  3  current state, for debug.

Function
REQ-020 Five states SHALL be used: IF=0, ID=1, EXE=2, MEM=3, WB=4.
REQ-021 Outputs SHALL be combinational functions of state, op, func, z and mem_ready, with no registered outputs.
REQ-022 Every output not stated active for a state SHALL be 0.
REQ-023 IF SHALL drive iord=0, alusrca=0, alusrcb=01, aluc=0000 (add) and pcsource=00.
REQ-024 In IF, wpc=wir=mem_ready, and IF→ID only when mem_ready=1; otherwise the FSM holds in IF.
REQ-025 ID SHALL drive alusrca=0, alusrcb=11, sext=1 and aluc=add (branch target captured into ALUOut).
REQ-026 ID with j SHALL drive wpc=1, pcsource=11, then go to IF.
REQ-027 ID with jal SHALL additionally drive wreg=1 and jal=1 (write PC+4 to r31), then go to IF.
REQ-028 ID with jr SHALL drive wpc=1, pcsource=10, then go to IF.
REQ-029 ID with an illegal op/func SHALL go to IF with all write enables 0 (executed as NOP).
REQ-030 All other legal instructions in ID SHALL go to EXE.
REQ-031 aluc encoding SHALL be: add/addi/lw/sw=0000; sub=0100; and/andi=0001; or/ori=0101; xor/xori=0010; lui=0110; sll=0011; srl=0111; sra=1111; hamming=1001; beq/bne=0010.
REQ-032 EXE SHALL drive alusrca=1, shift=1 for sll/srl/sra, alusrcb=10 for addi/andi/ori/xori/lui/lw/sw and 00 otherwise, and sext=1 for addi/lw/sw/beq/bne.
REQ-033 EXE with beq/bne SHALL drive pcsource=01 and wpc=(beq&z)|(bne&~z), then go to IF.
REQ-034 EXE with lw/sw SHALL go to MEM; all others SHALL go to WB.
REQ-035 MEM SHALL drive iord=1, with wmem=1 for sw for every cycle spent in MEM.
REQ-036 MEM exit SHALL occur only when mem_ready=1: sw→IF, lw→WB.
REQ-037 WB SHALL drive wreg=1, m2reg=1 for lw, and regrt=1 for addi/andi/ori/xori/lw/lui, then go to IF.
REQ-038 Latencies with zero wait states SHALL be: j/jal/jr 2 cycles, branch 3, ALU 4, sw 4, lw 5.
REQ-039 Each wait cycle (mem_ready=0 in IF or MEM) SHALL add exactly one cycle.
REQ-040 Encodings 5–7 SHALL drive all outputs 0 and go to IF on the next edge.
REQ-041 With MEM_WAIT_EN=0, IF and MEM SHALL each last exactly one cycle.
REQ-042 With HAMMING_EN=0, func 110001 SHALL follow the illegal path, with wreg never asserted.

Reset
REQ-043 reset=1 SHALL force state=IF immediately (asynchronous), independent of clock.
REQ-044 Under reset, wpc=wir=mem_ready and all other outputs SHALL take their IF values.
REQ-045 Reset asserted in MEM or WB SHALL drop wmem/wreg in the same cycle, with no write on the following edge.
REQ-046 After reset deassertion the FSM SHALL begin a fresh fetch.

Verification
REQ-047 add (op 000000, func 100000), mem_ready=1 → states 0,1,2,4,0; wreg=1 only in WB, regrt=0, aluc=0000.
REQ-048 lw (100011) with mem_ready=0 for 2 MEM cycles → states 0,1,2,3,3,3,4; iord=1 for 3 cycles; m2reg=wreg=1 in WB.
REQ-049 beq (000100) → EXE z=1: wpc=1, pcsource=01; EXE z=0: wpc=0. bne (000101) → the inverse.
REQ-050 jal (000011) → ID: wpc=wreg=jal=1, pcsource=11; next state IF.
REQ-051 sw (101011) with reset asserted mid-MEM → wmem falls with reset, state=0, no wmem on the next edge.
REQ-052 func 110001 → HAMMING_EN=1: WB with aluc=1001; HAMMING_EN=0: ID→IF, wreg=0 throughout.
